gpr_wr_sched: RTL and testbench

//  Write-port scheduler for the dual-read / single-write GPR file. Arbitrates the

---
 rtl/gpr_wr_sched_pkg.sv | 18 +
 rtl/gpr_wr_sched_wq.sv | 55 +++++
 rtl/gpr_wr_sched.sv | 118 +++++++++++
 tb/tb_gpr_wr_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wr_sched_pkg.sv
// Shared types and widths for the GPR write-port scheduler and its write queue.
package gpr_wr_sched_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StDone
    } sched_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wq_entry_t;

endpackage

// File: rtl/gpr_wr_sched_wq.sv
// DEPTH-entry write queue; taps are presented oldest (index 0 = head) to youngest.
module gpr_wr_sched_wq
    import gpr_wr_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enq_i,
    input  wq_entry_t                enq_entry_i,
    input  logic                     deq_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output wq_entry_t                tap_o [DEPTH],
    output logic [DEPTH-1:0]         tap_valid_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    wq_entry_t mem_q [DEPTH];
    ptr_t      head_q, tail_q;
    cnt_t      count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_i) tail_q <= tail_q + ptr_t'(1);
            if (deq_i) head_q <= head_q + ptr_t'(1);
            count_q <= count_q + cnt_t'(enq_i) - cnt_t'(deq_i);
        end
    end

    // Storage needs no reset: every tap is qualified by the count.
    always_ff @(posedge clk_i) begin
        if (enq_i) mem_q[tail_q] <= enq_entry_i;
    end

    always_comb begin
        ptr_t idx;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx            = head_q + ptr_t'(k);
            tap_o[k]       = mem_q[idx];
            tap_valid_o[k] = count_q > cnt_t'(k);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/gpr_wr_sched.sv
// GPR write-port scheduler: round-robin intake of WB/CSR write-backs into a small queue,
// same-cycle head commit, operand forwarding from queued entries and a drain handshake.
module gpr_wr_sched
    import gpr_wr_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              wb_ready_o,
    input  logic              csr_valid_i,
    input  logic [REG_AW-1:0] csr_rd_i,
    input  logic [XLEN-1:0]   csr_data_i,
    output logic              csr_ready_o,
    input  logic              wr_inhibit_i,
    output logic              gpr_we_o,
    output logic [REG_AW-1:0] gpr_rd_o,
    output logic [XLEN-1:0]   gpr_di_o,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    output logic              fwd1_hit_o,
    output logic [XLEN-1:0]   fwd1_data_o,
    output logic              fwd2_hit_o,
    output logic [XLEN-1:0]   fwd2_data_o,
    input  logic              drain_req_i,
    output logic              drain_ack_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    sched_state_e      state_q, state_d;
    logic              rr_q, rr_d;  // 0: WB has priority, 1: CSR has priority
    logic              enq, deq, accept, pick_csr;
    wq_entry_t         enq_entry;
    logic [CntW-1:0]   wq_count;
    wq_entry_t         taps [DEPTH];
    logic [DEPTH-1:0]  tap_valid;

    gpr_wr_sched_wq #(
        .DEPTH(DEPTH)
    ) u_wq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enq_i       (enq),
        .enq_entry_i (enq_entry),
        .deq_i       (deq),
        .count_o     (wq_count),
        .tap_o       (taps),
        .tap_valid_o (tap_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        deq      = (wq_count != '0) && !wr_inhibit_i;
        gpr_we_o = deq;
        gpr_rd_o = deq ? taps[0].rd : '0;
        gpr_di_o = deq ? taps[0].data : '0;

        pick_csr = csr_valid_i && (!wb_valid_i || rr_q);
        // A full queue still accepts when the head commits this cycle.
        accept   = !rst_i && (wb_valid_i || csr_valid_i) && (state_q == StRun) &&
                   ((wq_count < CntW'(DEPTH)) || deq);
        wb_ready_o  = accept && !pick_csr;
        csr_ready_o = accept && pick_csr;

        enq_entry.rd   = pick_csr ? csr_rd_i : wb_rd_i;
        enq_entry.data = pick_csr ? csr_data_i : wb_data_i;
        enq            = accept && (enq_entry.rd != '0);

        rr_d = rr_q;
        if (accept && wb_valid_i && csr_valid_i) rr_d = !pick_csr;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (drain_req_i) state_d = StDrain;
            StDrain: begin
                if (!drain_req_i)         state_d = StRun;
                else if (wq_count == '0)  state_d = StDone;
            end
            StDone:  if (!drain_req_i) state_d = StRun;
            default: state_d = StRun;
        endcase
        drain_ack_o = (state_q == StDone);
    end

    // Later taps are younger, so the last match wins.
    always_comb begin
        fwd1_hit_o  = 1'b0;
        fwd1_data_o = '0;
        fwd2_hit_o  = 1'b0;
        fwd2_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_valid[k] && (rs1_i != '0) && (taps[k].rd == rs1_i)) begin
                fwd1_hit_o  = 1'b1;
                fwd1_data_o = taps[k].data;
            end
            if (tap_valid[k] && (rs2_i != '0) && (taps[k].rd == rs2_i)) begin
                fwd2_hit_o  = 1'b1;
                fwd2_data_o = taps[k].data;
            end
        end
    end

endmodule

// File: tb/tb_gpr_wr_sched.sv
// Directed bench for gpr_wr_sched: per-cycle vector table plus reset and drain-abort sequences.
module tb_gpr_wr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, csr_valid, wr_inhibit, drain_req;
    logic [4:0]  wb_rd, csr_rd, rs1, rs2;
    logic [31:0] wb_data, csr_data;
    logic        wb_ready, csr_ready, gpr_we, fwd1_hit, fwd2_hit, drain_ack;
    logic [4:0]  gpr_rd;
    logic [31:0] gpr_di, fwd1_data, fwd2_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpr_wr_sched #(
        .DEPTH(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wb_valid_i   (wb_valid),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .wb_ready_o   (wb_ready),
        .csr_valid_i  (csr_valid),
        .csr_rd_i     (csr_rd),
        .csr_data_i   (csr_data),
        .csr_ready_o  (csr_ready),
        .wr_inhibit_i (wr_inhibit),
        .gpr_we_o     (gpr_we),
        .gpr_rd_o     (gpr_rd),
        .gpr_di_o     (gpr_di),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .fwd1_hit_o   (fwd1_hit),
        .fwd1_data_o  (fwd1_data),
        .fwd2_hit_o   (fwd2_hit),
        .fwd2_data_o  (fwd2_data),
        .drain_req_i  (drain_req),
        .drain_ack_o  (drain_ack)
    );

    typedef struct {
        logic        wv;  logic [4:0] wrd; logic [31:0] wd;
        logic        cv;  logic [4:0] crd; logic [31:0] cd;
        logic        inh; logic       drn; logic [4:0]  r1; logic [4:0] r2;
        logic        e_wr; logic e_cr; logic e_we; logic [4:0] e_rd; logic [31:0] e_di;
        logic        e_h1; logic [31:0] e_d1; logic e_h2; logic [31:0] e_d2; logic e_ack;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic cv, input logic [4:0] crd, input logic [31:0] cd,
                         input logic inh, input logic drn, input logic [4:0] r1,
                         input logic [4:0] r2);
        wb_valid = wv;  wb_rd = wrd;  wb_data = wd;
        csr_valid = cv; csr_rd = crd; csr_data = cd;
        wr_inhibit = inh; drain_req = drn; rs1 = r1; rs2 = r2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 5'd7, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.wb_ready", wb_ready, 0);
        chk("rst.gpr_we", gpr_we, 0);
        chk("rst.gpr_di", gpr_di, 0);
        chk("rst.fwd1_hit", fwd1_hit, 0);
        chk("rst.drain_ack", drain_ack, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //   wv wrd wd            cv crd cd         inh drn r1 r2 | wr cr we rd di ...
        add('{1, 5, 32'hDEADBEEF, 0, 0, 0,          0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 0, 5, 0,
              0, 0, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 0});
        // Contested intake alternates WB, CSR, WB, CSR.
        add('{1, 1, 32'h101,      1, 2, 32'h202,    0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{1, 6, 32'h106,      1, 2, 32'h202,    0, 0, 2, 1,
              0, 1, 1, 1, 32'h101, 0, 0, 1, 32'h101, 0});
        add('{1, 6, 32'h106,      1, 7, 32'h207,    0, 0, 0, 0,  1, 0, 1, 2, 32'h202, 0, 0, 0, 0, 0});
        add('{1, 8, 32'h108,      1, 7, 32'h207,    0, 0, 0, 0,  0, 1, 1, 6, 32'h106, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 0, 0, 0,  0, 0, 1, 7, 32'h207, 0, 0, 0, 0, 0});
        // Inhibited slot: fill, youngest-match forwarding, full + dequeue + enqueue.
        add('{1, 3, 32'h11,       0, 0, 0,          1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{1, 3, 32'h22,       0, 0, 0,          1, 0, 3, 0,  1, 0, 0, 0, 0, 1, 32'h11, 0, 0, 0});
        add('{1, 9, 32'h99,       0, 0, 0,          1, 0, 3, 9,  0, 0, 0, 0, 0, 1, 32'h22, 0, 0, 0});
        add('{1, 9, 32'h99,       0, 0, 0,          0, 0, 3, 0,
              1, 0, 1, 3, 32'h11, 1, 32'h22, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 0, 9, 0,
              0, 0, 1, 3, 32'h22, 1, 32'h99, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 0, 0, 0,  0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 0});
        // rd==0 handshakes but never reaches the queue.
        add('{1, 0, 32'hFFFF,     0, 0, 0,          0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // Drain with two queued and three inhibited cycles.
        add('{1, 10, 32'hA0,      0, 0, 0,          1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            1, 11, 32'hB0,    1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{1, 12, 32'hC0,      0, 0, 0,          1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{1, 12, 32'hC0,      0, 0, 0,          1, 1, 10, 11,
              0, 0, 0, 0, 0, 1, 32'hA0, 1, 32'hB0, 0});
        add('{1, 12, 32'hC0,      0, 0, 0,          1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{1, 12, 32'hC0,      0, 0, 0,          0, 1, 0, 0,  0, 0, 1, 10, 32'hA0, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 1, 0, 0,  0, 0, 1, 11, 32'hB0, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{1, 12, 32'hC0,      0, 0, 0,          0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        add('{1, 12, 32'hC0,      0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        add('{1, 12, 32'hC0,      0, 0, 0,          0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 0, 0, 0,  0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0});
        // Drain while empty: ack two cycles after the request.
        add('{0, 0, 0,            0, 0, 0,          0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        add('{0, 0, 0,            0, 0, 0,          0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        add('{0, 0, 0,            0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        add('{0, 0, 0,            0, 0, 0,          0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        foreach (vecs[i]) begin
            drive(vecs[i].wv, vecs[i].wrd, vecs[i].wd, vecs[i].cv, vecs[i].crd, vecs[i].cd,
                  vecs[i].inh, vecs[i].drn, vecs[i].r1, vecs[i].r2);
            @(negedge clk);
            chk($sformatf("v%0d.wb_ready", i), wb_ready, vecs[i].e_wr);
            chk($sformatf("v%0d.csr_ready", i), csr_ready, vecs[i].e_cr);
            chk($sformatf("v%0d.gpr_we", i), gpr_we, vecs[i].e_we);
            chk($sformatf("v%0d.gpr_rd", i), gpr_rd, vecs[i].e_rd);
            chk($sformatf("v%0d.gpr_di", i), gpr_di, vecs[i].e_di);
            chk($sformatf("v%0d.fwd1_hit", i), fwd1_hit, vecs[i].e_h1);
            chk($sformatf("v%0d.fwd1_data", i), fwd1_data, vecs[i].e_d1);
            chk($sformatf("v%0d.fwd2_hit", i), fwd2_hit, vecs[i].e_h2);
            chk($sformatf("v%0d.fwd2_data", i), fwd2_data, vecs[i].e_d2);
            chk($sformatf("v%0d.drain_ack", i), drain_ack, vecs[i].e_ack);
            next_cycle();
        end

        // Reset with a full queue and the round-robin pointer moved to CSR.
        drive(1, 4, 32'h44, 1, 5, 32'h55, 1, 0, 0, 0);
        @(negedge clk);
        chk("r6.fill_wb", wb_ready, 1);
        next_cycle();
        drive(0, 0, 0, 1, 5, 32'h55, 1, 0, 0, 0);
        @(negedge clk);
        chk("r6.fill_csr", csr_ready, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 4, 5);
        @(negedge clk);
        chk("r6.pre_hit1", fwd1_data, 32'h44);
        chk("r6.pre_hit2", fwd2_data, 32'h55);
        wr_inhibit = 1'b0;
        #1;
        chk("r6.pre_we", gpr_we, 1);
        rst = 1'b1;
        wb_valid = 1'b1;
        #1;
        chk("r6.rst_we", gpr_we, 0);
        chk("r6.rst_rd", gpr_rd, 0);
        chk("r6.rst_hit1", fwd1_hit, 0);
        chk("r6.rst_hit2", fwd2_hit, 0);
        chk("r6.rst_ready", wb_ready, 0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 5);
        @(negedge clk);
        chk("r6.post_we", gpr_we, 0);
        chk("r6.post_hit1", fwd1_hit, 0);
        next_cycle();
        drive(1, 13, 32'hD0, 1, 14, 32'hE0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r6.rr_wb", wb_ready, 1);
        chk("r6.rr_csr", csr_ready, 0);
        next_cycle();

        // Drain request withdrawn while in DRAIN returns to RUN.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("dab.we", gpr_we, 1);
        next_cycle();
        drive(1, 15, 32'hF0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("dab.drain_ready", wb_ready, 0);
        chk("dab.drain_ack", drain_ack, 0);
        next_cycle();
        @(negedge clk);
        chk("dab.run_ready", wb_ready, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("dab.commit_rd", gpr_rd, 15);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
